// File: rtl/imem_pkg.sv
// Shared types for the instruction-memory responder.
// FSM state enum, queued request record, wait-counter width.
package imem_pkg;

  localparam int unsigned WAIT_W = 4;
  localparam int unsigned WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } imem_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] word_addr;
    logic              err;
  } imem_req_t;

endpackage

// File: rtl/fetch_req_fifo.sv
// Synchronous FIFO of accepted fetch requests.
// Ports: push/data in, pop, full/empty flags, head entry out.
module fetch_req_fifo
  import imem_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push,
  input  imem_req_t data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output imem_req_t head
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  imem_req_t         mem [DEPTH];
  logic [PW-1:0]     wr_q;
  logic [PW-1:0]     rd_q;
  logic [CW-1:0]     cnt_q;
  logic              do_push;
  logic              do_pop;

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_q];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_q] <= data;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push)
        wr_q <= (wr_q == PW'(DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (do_pop)
        rd_q <= (rd_q == PW'(DEPTH - 1)) ? '0 : rd_q + PW'(1);
      if (do_push && !do_pop)
        cnt_q <= cnt_q + CW'(1);
      else if (!do_push && do_pop)
        cnt_q <= cnt_q - CW'(1);
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Fetch-port responder: queues req/gnt requests, reads SRAM after
// wait states, returns in-order rvalid/rdata/err. SRAM port is 1-cycle.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned     XLEN            = 32,
  parameter logic [XLEN-1:0] BASE_ADDR       = 32'h4000_0000,
  parameter int unsigned     DEPTH_WORDS     = 1024,
  parameter int unsigned     WAIT_CYCLES     = 0,
  parameter int unsigned     MAX_OUTSTANDING = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i,
  input  logic [XLEN-1:0]                addr_i,
  output logic                           gnt_o,
  output logic                           rvalid_o,
  output logic [XLEN-1:0]                rdata_o,
  output logic                           err_o,
  output logic                           sram_en_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] sram_addr_o,
  input  logic [XLEN-1:0]                sram_rdata_i
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN:0] LIMIT =
    {1'b0, BASE_ADDR} + ((XLEN+1)'(DEPTH_WORDS) << 2);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  imem_state_e       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [AW-1:0]     addr_q;
  logic [XLEN-1:0]   offset;
  imem_req_t         req_in;
  imem_req_t         head;
  logic              full;
  logic              empty;
  logic              pop;
  logic              unused_waddr;

  assign gnt_o  = !full;
  assign offset = addr_i - BASE_ADDR;

  always_comb begin
    req_in.word_addr = WORD_W'(offset >> 2);
    req_in.err = (addr_i[1:0] != 2'b00)
              || (addr_i < BASE_ADDR)
              || ({1'b0, addr_i} >= LIMIT);
  end

  fetch_req_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (req_i && gnt_o),
    .data   (req_in),
    .pop    (pop),
    .full   (full),
    .empty  (empty),
    .head   (head)
  );

  assign unused_waddr = ^(head.word_addr >> AW);

  // IDLE and RESP share dispatch of the next head so that
  // responses can run back to back.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    pop       = 1'b0;
    sram_en_o = 1'b0;
    unique case (state_q)
      IDLE, RESP: begin
        if (empty) begin
          state_d = IDLE;
        end else if (head.err) begin
          pop     = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
        end else if (WAIT_CYCLES == 0) begin
          sram_en_o = 1'b1;
          pop       = 1'b1;
          err_d     = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - WAIT_W'(1);
        if (cnt_q == WAIT_W'(1)) begin
          sram_en_o = 1'b1;
          pop       = 1'b1;
          err_d     = 1'b0;
          state_d   = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (sram_en_o) addr_q <= head.word_addr[AW-1:0];
    end
  end

  assign sram_addr_o = sram_en_o ? head.word_addr[AW-1:0] : addr_q;
  assign rvalid_o    = (state_q == RESP);
  assign err_o       = rvalid_o && err_q;
  assign rdata_o     = (rvalid_o && !err_q) ? sram_rdata_i : '0;

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder (WAIT_CYCLES=2, 2 outstanding).
// Stimulus pushes expectations; a negedge monitor pops and compares.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic        sram_en;
  logic [9:0]  sram_addr;
  logic [31:0] sram_rdata = '0;

  always #5 clk = ~clk;

  imem_responder #(
    .XLEN            (32),
    .BASE_ADDR       (32'h4000_0000),
    .DEPTH_WORDS     (1024),
    .WAIT_CYCLES     (2),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_i        (req),
    .addr_i       (addr),
    .gnt_o        (gnt),
    .rvalid_o     (rvalid),
    .rdata_o      (rdata),
    .err_o        (err),
    .sram_en_o    (sram_en),
    .sram_addr_o  (sram_addr),
    .sram_rdata_i (sram_rdata)
  );

  logic [31:0] mem [1024];

  always @(posedge clk) if (sram_en) sram_rdata <= mem[sram_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  int tests = 0;
  int fails = 0;
  int en_cnt = 0;
  int en_cyc = -1;
  logic [9:0] en_addr = '0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (sram_en) begin
      en_cnt++;
      en_cyc  = cyc;
      en_addr = sram_addr;
    end
    if (rvalid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL rvalid_no_pending: got rvalid=1 at cycle %0d expected 0", cyc);
      end else begin
        e = sb.pop_front();
        chk("rdata", rdata, e.data);
        chk("err", {31'b0, err}, {31'b0, e.err});
        if (e.cyc >= 0) chk("resp_cycle", cyc, e.cyc);
      end
    end else begin
      chk("idle_rdata", rdata, 32'h0);
      chk("idle_err", {31'b0, err}, 32'h0);
    end
  end

  // lat: expected cycles from handshake to rvalid, or -1 for don't care.
  task automatic send(input logic [31:0] a, input logic [31:0] d,
                      input logic er, input int lat, output int t);
    int n = 0;
    exp_t x;
    req  = 1'b1;
    addr = a;
    while (!gnt && n < 100) begin
      @(negedge clk);
      n++;
    end
    t = cyc;
    if (!gnt) begin
      chk("gnt_timeout", {31'b0, gnt}, 32'h1);
    end else begin
      x.data = d;
      x.err  = er;
      x.cyc  = (lat < 0) ? -1 : cyc + lat;
      sb.push_back(x);
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  int t, c0;
  int ts [8];
  int cap_off [8] = '{0, 1, 4, 7, 10, 13, 16, 19};

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
    mem[0] = 32'h0000_0013;
    rst_n = 1'b0;
    req   = 1'b0;
    addr  = '0;
    repeat (3) @(negedge clk);
    chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_sram_en", {31'b0, sram_en}, 32'h0);
    chk("rst_sram_addr", {22'b0, sram_addr}, 32'h0);
    chk("rst_gnt", {31'b0, gnt}, 32'h1);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single fetch latency: en at T+3, rvalid at T+4.
    send(32'h4000_0000, 32'h0000_0013, 1'b0, 4, t);
    drain();
    chk("lat_en_cycle", en_cyc, t + 3);
    chk("lat_en_addr", {22'b0, en_addr}, 32'h0);

    // Four sequential fetches: one response every 3 cycles.
    send(32'h4000_0000, 32'h0000_0013, 1'b0, 4, ts[0]);
    send(32'h4000_0004, 32'hC0DE_0001, 1'b0, 6, ts[1]);
    send(32'h4000_0008, 32'hC0DE_0002, 1'b0, 6, ts[2]);
    send(32'h4000_000C, 32'hC0DE_0003, 1'b0, 6, ts[3]);
    drain();
    chk("seq_acc1", ts[1] - ts[0], 1);
    chk("seq_acc2", ts[2] - ts[0], 4);
    chk("seq_acc3", ts[3] - ts[0], 7);
    chk("seq_last_addr", {22'b0, en_addr}, 32'h3);

    // Error responses: no wait states, no SRAM access.
    c0 = en_cnt;
    send(32'h3FFF_FFFC, 32'h0, 1'b1, 2, t);
    send(32'h4000_1000, 32'h0, 1'b1, 2, t);
    send(32'h4000_0002, 32'h0, 1'b1, 2, t);
    drain();
    chk("err_no_sram", en_cnt, c0);

    // Capacity with req held high.
    for (int i = 0; i < 8; i++)
      send(32'h4000_0100 + 4 * i, 32'hC0DE_0040 + i, 1'b0,
           (i == 0) ? 4 : 6, ts[i]);
    drain();
    for (int i = 1; i < 8; i++)
      chk($sformatf("cap_acc%0d", i), ts[i] - ts[0], cap_off[i]);

    // Mixed: valid, err, valid; the err response follows immediately.
    send(32'h4000_0010, 32'hC0DE_0004, 1'b0, 4, t);
    send(32'h4000_0003, 32'h0, 1'b1, 4, t);
    send(32'h4000_0014, 32'hC0DE_0005, 1'b0, 4, t);
    drain();
    chk("mix_last_addr", {22'b0, en_addr}, 32'h5);

    // Reset with the queue full and the head in WAIT.
    send(32'h4000_0020, 32'hC0DE_0008, 1'b0, -1, t);
    send(32'h4000_0024, 32'hC0DE_0009, 1'b0, -1, t);
    chk("pre_rst_gnt", {31'b0, gnt}, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rvalid", {31'b0, rvalid}, 32'h0);
    chk("mid_rst_sram_en", {31'b0, sram_en}, 32'h0);
    chk("mid_rst_sram_addr", {22'b0, sram_addr}, 32'h0);
    chk("mid_rst_gnt", {31'b0, gnt}, 32'h1);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    send(32'h4000_0004, 32'hC0DE_0001, 1'b0, 4, t);
    drain();
    chk("post_rst_en_cycle", en_cyc, t + 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
